// File: rtl/relay_link_sched_pkg.sv
// Shared codes, types and helpers for the relay link scheduler.
// Covers the role codes, the mod_type codes, the per-role SOF nibbles and the FSM state type.
package relay_link_sched_pkg;

   localparam int unsigned ROLE_W  = 3;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned GUARD_W = 10;

   localparam int unsigned EOF_ZERO_NIB_DEF  = 4;
   localparam int unsigned IDLE_ZERO_NIB_DEF = 4;
   localparam int unsigned MAX_FRAME_NIB_DEF = 128;
   localparam int unsigned GUARD_CYCLES_DEF  = 64;

   localparam logic [ROLE_W-1:0] ROLE_FAKE_READER = 3'b101;
   localparam logic [ROLE_W-1:0] ROLE_FAKE_TAG    = 3'b110;

   localparam logic [ROLE_W-1:0] MT_OFF        = 3'b000;
   localparam logic [ROLE_W-1:0] MT_RDR_LISTEN = 3'b011;
   localparam logic [ROLE_W-1:0] MT_RDR_MOD    = 3'b100;
   localparam logic [ROLE_W-1:0] MT_TAG_LISTEN = 3'b001;
   localparam logic [ROLE_W-1:0] MT_TAG_MOD    = 3'b010;

   localparam logic [NIB_W-1:0] SOF_RDR = 4'hc;
   localparam logic [NIB_W-1:0] SOF_TAG = 4'hf;

   typedef enum logic [1:0] {
      ST_DIS    = 2'd0,
      ST_LISTEN = 2'd1,
      ST_MOD    = 2'd2,
      ST_GUARD  = 2'd3
   } state_e;

   typedef struct packed {
      logic [ROLE_W-1:0] mod_type;
      logic              enc_enable;
      logic              frame_active;
      logic [LEN_W-1:0]  frame_len;
      logic              err_overflow;
      logic              err_sof;
   } link_out_t;

   function automatic logic role_valid(input logic [ROLE_W-1:0] role);
      return (role == ROLE_FAKE_READER) || (role == ROLE_FAKE_TAG);
   endfunction

   function automatic logic [ROLE_W-1:0] listen_code(input logic [ROLE_W-1:0] role);
      return (role == ROLE_FAKE_READER) ? MT_RDR_LISTEN : MT_TAG_LISTEN;
   endfunction

   function automatic logic [ROLE_W-1:0] mod_code(input logic [ROLE_W-1:0] role);
      return (role == ROLE_FAKE_READER) ? MT_RDR_MOD : MT_TAG_MOD;
   endfunction

   function automatic logic [NIB_W-1:0] sof_nib(input logic [ROLE_W-1:0] role);
      return (role == ROLE_FAKE_READER) ? SOF_RDR : SOF_TAG;
   endfunction

endpackage

// File: rtl/relay_link_sched_zero_run.sv
// Saturating run counter of consecutive 0x0 nibbles; shared by idle and EOF detection.
module relay_link_sched_zero_run #(
   parameter int unsigned SAT        = 4,
   parameter int unsigned PRESET_VAL = 4,
   parameter int unsigned W          = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         preset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (preset) begin
         cnt_d = W'(PRESET_VAL);
      end else if (inc && (cnt_q < W'(SAT))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/relay_link_sched.sv
// Half-duplex scheduler for the relay wire: frames decoded nibbles (SOF/EOF), owns mod_type,
// gates the encoder, and enforces turnaround guard, frame-length limit and error flags.
module relay_link_sched
   import relay_link_sched_pkg::*;
#(
   parameter int unsigned EOF_ZERO_NIB  = EOF_ZERO_NIB_DEF,
   parameter int unsigned IDLE_ZERO_NIB = IDLE_ZERO_NIB_DEF,
   parameter int unsigned MAX_FRAME_NIB = MAX_FRAME_NIB_DEF,
   parameter int unsigned GUARD_CYCLES  = GUARD_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ROLE_W-1:0] hi_sim_mode,
   input  logic [NIB_W-1:0]  nib,
   input  logic              nib_valid,
   output logic [ROLE_W-1:0] mod_type,
   output logic              enc_enable,
   output logic              frame_active,
   output logic [LEN_W-1:0]  frame_len,
   output logic              err_overflow,
   output logic              err_sof
);

   localparam int unsigned ZR_SAT = (EOF_ZERO_NIB > IDLE_ZERO_NIB) ? EOF_ZERO_NIB : IDLE_ZERO_NIB;
   localparam int unsigned ZR_W   = $clog2(ZR_SAT + 1);

   state_e              state_q, state_d;
   logic [ROLE_W-1:0]   mode_q;
   logic [GUARD_W-1:0]  guard_q, guard_d;
   link_out_t           out_q, out_d;
   logic [LEN_W-1:0]    len_d, len_inc;
   logic                eo_d, es_d;
   logic                zr_clr, zr_preset, zr_inc;
   logic [ZR_W-1:0]     zr_cnt;
   logic                role_chg;

   relay_link_sched_zero_run #(
      .SAT        (ZR_SAT),
      .PRESET_VAL (IDLE_ZERO_NIB),
      .W          (ZR_W)
   ) u_zero_run (
      .clk    (clk),
      .reset  (reset),
      .clr    (zr_clr),
      .preset (zr_preset),
      .inc    (zr_inc),
      .cnt    (zr_cnt)
   );

   // Next state, counters, flags and the registered output image.
   always_comb begin
      state_d   = state_q;
      guard_d   = guard_q;
      len_d     = out_q.frame_len;
      eo_d      = out_q.err_overflow;
      es_d      = out_q.err_sof;
      zr_clr    = 1'b0;
      zr_preset = 1'b0;
      zr_inc    = 1'b0;
      out_d     = '0;
      role_chg  = (hi_sim_mode != mode_q);
      len_inc   = (out_q.frame_len == {LEN_W{1'b1}}) ? out_q.frame_len
                                                      : out_q.frame_len + LEN_W'(1);

      if (role_chg) begin
         // Role change wins over everything, including a same-cycle nibble.
         state_d = ST_DIS;
         guard_d = '0;
         len_d   = '0;
         eo_d    = 1'b0;
         es_d    = 1'b0;
         zr_clr  = 1'b1;
      end else begin
         case (state_q)
            ST_DIS: begin
               zr_clr = 1'b1;
               if (role_valid(mode_q)) begin
                  state_d = ST_LISTEN;
               end
            end
            ST_LISTEN: begin
               if (nib_valid) begin
                  if (nib == sof_nib(mode_q)) begin
                     zr_clr = 1'b1;
                     if (zr_cnt >= ZR_W'(IDLE_ZERO_NIB)) begin
                        state_d = ST_MOD;
                        len_d   = LEN_W'(1);
                     end else begin
                        es_d = 1'b1;
                     end
                  end else if (nib == '0) begin
                     zr_inc = 1'b1;
                  end else begin
                     zr_clr = 1'b1;
                  end
               end
            end
            ST_MOD: begin
               if (nib_valid) begin
                  len_d = len_inc;
                  if (nib == '0) begin
                     zr_inc = 1'b1;
                  end else begin
                     zr_clr = 1'b1;
                  end
                  // EOF only on a byte boundary; otherwise keep counting toward the limit.
                  if ((nib == '0) && (zr_cnt >= ZR_W'(EOF_ZERO_NIB - 1)) && !len_inc[0]) begin
                     state_d = ST_GUARD;
                     guard_d = GUARD_W'(GUARD_CYCLES - 1);
                  end else if (len_inc == LEN_W'(MAX_FRAME_NIB)) begin
                     state_d = ST_GUARD;
                     guard_d = GUARD_W'(GUARD_CYCLES - 1);
                     eo_d    = 1'b1;
                  end
               end
            end
            ST_GUARD: begin
               if (guard_q == '0) begin
                  state_d   = ST_LISTEN;
                  zr_preset = 1'b1;
               end else begin
                  guard_d = guard_q - GUARD_W'(1);
               end
            end
            default: begin
               state_d = ST_DIS;
            end
         endcase
      end

      out_d.frame_len    = len_d;
      out_d.err_overflow = eo_d;
      out_d.err_sof      = es_d;
      case (state_d)
         ST_LISTEN: begin
            out_d.mod_type   = listen_code(mode_q);
            out_d.enc_enable = 1'b1;
         end
         ST_MOD: begin
            out_d.mod_type     = mod_code(mode_q);
            out_d.frame_active = 1'b1;
         end
         ST_GUARD: begin
            out_d.mod_type = listen_code(mode_q);
         end
         default: begin
            out_d.mod_type = MT_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_DIS;
         mode_q  <= '0;
         guard_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= hi_sim_mode;
         guard_q <= guard_d;
         out_q   <= out_d;
      end
   end

   assign mod_type     = out_q.mod_type;
   assign enc_enable   = out_q.enc_enable;
   assign frame_active = out_q.frame_active;
   assign frame_len    = out_q.frame_len;
   assign err_overflow = out_q.err_overflow;
   assign err_sof      = out_q.err_sof;

endmodule
